// File: rtl/sdp_ram_if.sv
// rtl/sdp_ram_if.sv - port bundle for the simple dual-port RAM
interface sdp_ram_if #(
   parameter int DW = 8,
   parameter int AW = 10
);
   logic [AW-1:0] addr_a;
   logic          wr_a;
   logic [DW-1:0] din_a;
   logic [AW-1:0] addr_b;
   logic [DW-1:0] qout_b;

   modport master (output addr_a, wr_a, din_a, addr_b, input qout_b);
   modport slave  (input addr_a, wr_a, din_a, addr_b, output qout_b);
endinterface

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, write port A, read port B
module sdp_ram #(
   parameter int    DW        = 8,
   parameter int    WORDS     = 1024,
   parameter string READ_MODE = "RF"
) (
   input logic      clk,
   input logic      rst,
   sdp_ram_if.slave bus
);
   localparam int          AW      = (WORDS > 2) ? $clog2(WORDS) : 1;
   localparam logic [31:0] WORDS_U = WORDS;

   // No reset on the array so the tools keep RAM inference.
   logic [DW-1:0] mem_q [WORDS] = '{default: '0};

   logic          wr_in_range;
   logic          rd_in_range;
   logic [DW-1:0] rd_word;

   assign wr_in_range = 32'(bus.addr_a) < WORDS_U;
   assign rd_in_range = 32'(bus.addr_b) < WORDS_U;

   always_ff @(posedge clk) begin
      if (bus.wr_a && wr_in_range) begin
         mem_q[bus.addr_a] <= bus.din_a;
      end
   end

   assign rd_word = rd_in_range ? mem_q[bus.addr_b] : '0;

   if (WORDS < 2) begin : g_bad_words
      $error("sdp_ram: WORDS must be at least 2");
   end

   if ($bits(bus.addr_a) != AW) begin : g_bad_aw
      $error("sdp_ram: interface address width does not match WORDS");
   end

   if (READ_MODE == "RF") begin : g_rf
      logic [DW-1:0] qout_q;
      logic [DW-1:0] qout_d;

      // Sampling before the write lands gives read-first collisions.
      assign qout_d = rst ? '0 : rd_word;

      always_ff @(posedge clk) begin
         qout_q <= qout_d;
      end

      assign bus.qout_b = qout_q;
   end else if (READ_MODE == "RA") begin : g_ra
      logic unused_rst;
      assign unused_rst = rst;
      assign bus.qout_b = rd_word;
   end else begin : g_bad_mode
      $error("sdp_ram: READ_MODE must be \"RF\" or \"RA\"");
   end
endmodule

// File: tb/tb_sdp_ram.sv
// tb/tb_sdp_ram.sv - bench for sdp_ram, both read modes, 16 and 12 words
`timescale 1ns/100ps
module tb_sdp_ram;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] addr_a = '0;
   logic       wr_a = 1'b0;
   logic [7:0] din_a = '0;
   logic [3:0] addr_b = '0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   sdp_ram_if #(.DW(8), .AW(4)) if_rf16 ();
   sdp_ram_if #(.DW(8), .AW(4)) if_ra16 ();
   sdp_ram_if #(.DW(8), .AW(4)) if_rf12 ();
   sdp_ram_if #(.DW(8), .AW(4)) if_ra12 ();

   assign if_rf16.addr_a = addr_a; assign if_rf16.wr_a = wr_a;
   assign if_rf16.din_a  = din_a;  assign if_rf16.addr_b = addr_b;
   assign if_ra16.addr_a = addr_a; assign if_ra16.wr_a = wr_a;
   assign if_ra16.din_a  = din_a;  assign if_ra16.addr_b = addr_b;
   assign if_rf12.addr_a = addr_a; assign if_rf12.wr_a = wr_a;
   assign if_rf12.din_a  = din_a;  assign if_rf12.addr_b = addr_b;
   assign if_ra12.addr_a = addr_a; assign if_ra12.wr_a = wr_a;
   assign if_ra12.din_a  = din_a;  assign if_ra12.addr_b = addr_b;

   sdp_ram #(.DW(8), .WORDS(16), .READ_MODE("RF")) u_rf16 (.clk(clk), .rst(rst), .bus(if_rf16));
   sdp_ram #(.DW(8), .WORDS(16), .READ_MODE("RA")) u_ra16 (.clk(clk), .rst(rst), .bus(if_ra16));
   sdp_ram #(.DW(8), .WORDS(12), .READ_MODE("RF")) u_rf12 (.clk(clk), .rst(rst), .bus(if_rf12));
   sdp_ram #(.DW(8), .WORDS(12), .READ_MODE("RA")) u_ra12 (.clk(clk), .rst(rst), .bus(if_ra12));

   // Reference: plain arrays; the 12-word one drops out-of-range writes.
   logic [7:0] m16 [16];
   logic [7:0] m12 [16];
   logic [7:0] exp_rf16 = '0;
   logic [7:0] exp_rf12 = '0;
   bit         started = 1'b0;

   initial begin
      for (int i = 0; i < 16; i++) begin
         m16[i] = '0;
         m12[i] = '0;
      end
   end

   function automatic logic [7:0] ra16_exp();
      return m16[addr_b];
   endfunction

   function automatic logic [7:0] ra12_exp();
      return (addr_b < 4'd12) ? m12[addr_b] : 8'h00;
   endfunction

   always @(posedge clk) begin
      exp_rf16 = rst ? 8'h00 : m16[addr_b];
      exp_rf12 = rst ? 8'h00 : ra12_exp();
      if (wr_a) begin
         m16[addr_a] = din_a;
         if (addr_a < 4'd12) m12[addr_a] = din_a;
      end
      started = 1'b1;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%02h expected 0x%02h (addr_b=%0d t=%0t)", name, act, exp, addr_b, $time);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (started) begin
         check("rf16_model", if_rf16.qout_b, exp_rf16);
         check("rf12_model", if_rf12.qout_b, exp_rf12);
         check("ra16_model", if_ra16.qout_b, ra16_exp());
         check("ra12_model", if_ra12.qout_b, ra12_exp());
      end
   end

   // Mid-cycle check: the asynchronous port follows addr_b with no clock.
   always @(negedge clk) begin
      #2;
      if (started) begin
         check("ra16_comb", if_ra16.qout_b, ra16_exp());
         check("ra12_comb", if_ra12.qout_b, ra12_exp());
      end
   end

   task automatic cyc(input logic w, input logic [3:0] aa, input logic [7:0] d,
                      input logic [3:0] ab, input logic r);
      @(negedge clk);
      wr_a = w; addr_a = aa; din_a = d; addr_b = ab; rst = r;
      @(posedge clk);
      #2;
   endtask

   initial begin
      cyc(1'b0, 4'd0, 8'h00, 4'd0, 1'b1);
      check("reset_rf16", if_rf16.qout_b, 8'h00);

      // Write then delayed registered read
      cyc(1'b1, 4'd3, 8'hA5, 4'd3, 1'b0);
      check("rf_before_write", if_rf16.qout_b, 8'h00);
      cyc(1'b0, 4'd0, 8'h00, 4'd3, 1'b0);
      check("rf_after_write", if_rf16.qout_b, 8'hA5);

      // Read-first collision
      cyc(1'b1, 4'd5, 8'h11, 4'd0, 1'b0);
      cyc(1'b1, 4'd5, 8'h22, 4'd5, 1'b0);
      check("rf_collision_old", if_rf16.qout_b, 8'h11);
      cyc(1'b0, 4'd0, 8'h00, 4'd5, 1'b0);
      check("rf_collision_new", if_rf16.qout_b, 8'h22);

      // Output reset keeps contents
      cyc(1'b0, 4'd0, 8'h00, 4'd5, 1'b1);
      check("rf_reset_out", if_rf16.qout_b, 8'h00);
      check("ra_reset_ignored", if_ra16.qout_b, 8'h22);
      cyc(1'b0, 4'd0, 8'h00, 4'd5, 1'b0);
      check("rf_reset_kept", if_rf16.qout_b, 8'h22);

      // Asynchronous read, same cycle
      cyc(1'b1, 4'd7, 8'h3C, 4'd0, 1'b0);
      @(negedge clk);
      wr_a = 1'b0; addr_b = 4'd7;
      #1 check("ra_same_cycle", if_ra16.qout_b, 8'h3C);
      addr_b = 4'd8;
      #2 check("ra_unwritten", if_ra16.qout_b, 8'h00);

      // Full sweep, value i ^ 0x5A
      for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 8'(i) ^ 8'h5A, 4'd0, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b0, 4'd0, 8'h00, 4'(i), 1'b0);
      check("sweep_rf16_last", if_rf16.qout_b, 8'h55);
      check("sweep_ra16_last", if_ra16.qout_b, 8'h55);
      check("sweep_ra12_oob", if_ra12.qout_b, 8'h00);
      check("sweep_rf12_oob", if_rf12.qout_b, 8'h00);
      cyc(1'b0, 4'd0, 8'h00, 4'd11, 1'b0);
      check("sweep_rf12_top", if_rf12.qout_b, 8'h51);

      // Reset does not block the async read nor writes
      cyc(1'b0, 4'd0, 8'h00, 4'd4, 1'b1);
      check("ra_rst_read", if_ra16.qout_b, 8'h5E);
      cyc(1'b1, 4'd9, 8'h77, 4'd9, 1'b1);
      check("ra_rst_write", if_ra16.qout_b, 8'h77);
      check("rf_rst_write_out", if_rf16.qout_b, 8'h00);
      cyc(1'b0, 4'd0, 8'h00, 4'd9, 1'b0);
      check("rf_rst_write_landed", if_rf16.qout_b, 8'h77);

      for (int n = 0; n < 2000; n++) begin
         cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 15) == 0));
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
